// File: rtl/kmeans_centroid_update_k3_d4.sv
// kmeans_centroid_update_k3_d4: accumulates classified points into per-centroid
// per-dimension sums and counts, then divides sum/count and streams 12 results.
// Ports: clk, rst (async active-high); start, in_valid, in_last,
//   input_data0..3, selected_centroid (point in); out_valid/out_ready handshake
//   with out_centroid, out_dim, out_data, out_empty; busy, done, acc_overflow.
module kmeans_centroid_update_k3_d4 #(
    parameter int input_data_width = 16,
    parameter int acc_width        = 32,
    parameter int cnt_width        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic [input_data_width-1:0] input_data0,
    input  logic [input_data_width-1:0] input_data1,
    input  logic [input_data_width-1:0] input_data2,
    input  logic [input_data_width-1:0] input_data3,
    input  logic [1:0]                  selected_centroid,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [1:0]                  out_centroid,
    output logic [1:0]                  out_dim,
    output logic [input_data_width-1:0] out_data,
    output logic                        out_empty,
    output logic                        busy,
    output logic                        done,
    output logic                        acc_overflow
);
    localparam int SW = $clog2(acc_width + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DIV, OUT} state_t;
    state_t r_state, w_next;

    logic [acc_width-1:0] r_sum [3][4];
    logic [cnt_width-1:0] r_cnt [3];
    logic                 r_ovf;
    logic                 r_done;
    logic                 r_empty;
    logic [1:0]           r_k;
    logic [1:0]           r_d;
    logic [SW-1:0]        r_step;
    logic [acc_width-1:0] r_rem;
    logic [acc_width-1:0] r_quo;
    logic [cnt_width-1:0] r_dvs;

    logic [input_data_width-1:0] w_in [4];
    logic [acc_width-1:0]        w_sel_sum [4];
    logic [cnt_width-1:0]        w_sel_cnt;
    logic [acc_width:0]          w_add [4];
    logic [cnt_width:0]          w_inc;
    logic                        w_carry;
    logic                        w_hit;
    logic                        w_clear;
    logic [acc_width-1:0]        w_div_sum;
    logic [cnt_width-1:0]        w_div_cnt;
    logic [acc_width:0]          w_shift;
    logic [acc_width:0]          w_diff;
    logic                        w_neg;
    logic                        w_last_pair;

    assign w_in[0] = input_data0;
    assign w_in[1] = input_data1;
    assign w_in[2] = input_data2;
    assign w_in[3] = input_data3;

    // selected_centroid == 3 is a dropped point
    assign w_hit   = in_valid && (selected_centroid != 2'd3);
    assign w_clear = start && (r_state == IDLE || r_state == ACCUM);

    always_comb begin
        w_sel_cnt = r_cnt[2];
        for (int d = 0; d < 4; d++) w_sel_sum[d] = r_sum[2][d];
        for (int k = 0; k < 2; k++) begin
            if (selected_centroid == 2'(k)) begin
                w_sel_cnt = r_cnt[k];
                for (int d = 0; d < 4; d++) w_sel_sum[d] = r_sum[k][d];
            end
        end
    end

    always_comb begin
        w_carry = 1'b0;
        for (int d = 0; d < 4; d++) begin
            w_add[d] = {1'b0, w_sel_sum[d]} + (acc_width + 1)'(w_in[d]);
            w_carry  = w_carry | w_add[d][acc_width];
        end
        w_inc   = {1'b0, w_sel_cnt} + (cnt_width + 1)'(1);
        w_carry = w_carry | w_inc[cnt_width];
    end

    always_comb begin
        w_div_sum = r_sum[2][r_d];
        w_div_cnt = r_cnt[2];
        for (int k = 0; k < 2; k++) begin
            if (r_k == 2'(k)) begin
                w_div_sum = r_sum[k][r_d];
                w_div_cnt = r_cnt[k];
            end
        end
    end

    // restoring step: shift next dividend bit into the partial remainder
    assign w_shift = {r_rem, r_quo[acc_width-1]};
    assign w_diff  = w_shift - (acc_width + 1)'(r_dvs);
    assign w_neg   = w_diff[acc_width];

    assign w_last_pair = (r_k == 2'd2) && (r_d == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (start) w_next = ACCUM;
            ACCUM: if (!start && in_valid && in_last) w_next = DIV;
            DIV: begin
                if ((r_step == SW'(1) && r_empty) ||
                    r_step == SW'(acc_width))
                    w_next = OUT;
            end
            OUT: begin
                if (out_ready) w_next = w_last_pair ? IDLE : DIV;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                r_cnt[k] <= '0;
                for (int d = 0; d < 4; d++) r_sum[k][d] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_clear) begin
            for (int k = 0; k < 3; k++) begin
                r_cnt[k] <= '0;
                for (int d = 0; d < 4; d++) r_sum[k][d] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (r_state == ACCUM && w_hit) begin
            for (int k = 0; k < 3; k++) begin
                if (selected_centroid == 2'(k)) begin
                    r_cnt[k] <= w_inc[cnt_width-1:0];
                    for (int d = 0; d < 4; d++)
                        r_sum[k][d] <= w_add[d][acc_width-1:0];
                end
            end
            if (w_carry) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_empty <= 1'b0;
            r_step  <= '0;
            r_k     <= '0;
            r_d     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ACCUM: begin
                    if (!start && in_valid && in_last) begin
                        r_k    <= '0;
                        r_d    <= '0;
                        r_step <= '0;
                    end
                end
                DIV: begin
                    r_step <= r_step + SW'(1);
                    if (r_step == '0) begin
                        // load cycle; an empty cluster yields a forced 0
                        r_rem   <= '0;
                        r_dvs   <= w_div_cnt;
                        r_empty <= (w_div_cnt == '0);
                        r_quo   <= (w_div_cnt == '0) ? '0 : w_div_sum;
                    end else if (!r_empty) begin
                        r_rem <= w_neg ? w_shift[acc_width-1:0]
                                       : w_diff[acc_width-1:0];
                        r_quo <= {r_quo[acc_width-2:0], ~w_neg};
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_step <= '0;
                        if (r_d == 2'd3) begin
                            r_d <= '0;
                            if (r_k == 2'd2) begin
                                r_k    <= '0;
                                r_done <= 1'b1;
                            end else begin
                                r_k <= r_k + 2'd1;
                            end
                        end else begin
                            r_d <= r_d + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid    = (r_state == OUT);
    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign acc_overflow = r_ovf;
    assign out_centroid = r_k;
    assign out_dim      = r_d;
    assign out_data     = out_valid ? r_quo[input_data_width-1:0] : '0;
    assign out_empty    = out_valid && r_empty;
endmodule

// File: tb/tb_kmeans_centroid_update_k3_d4.sv
// tb_kmeans_centroid_update_k3_d4: directed epochs checked against a
// mean-per-cluster model, with literal pins on the model results.
module tb_kmeans_centroid_update_k3_d4;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic [1:0]  sel = '0;
    logic        out_valid, out_empty, busy, done, ovf;
    logic [1:0]  oc, od;
    logic [15:0] odata;

    always #5 clk = ~clk;

    kmeans_centroid_update_k3_d4 dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_last(in_last),
        .input_data0(d0), .input_data1(d1),
        .input_data2(d2), .input_data3(d3),
        .selected_centroid(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_centroid(oc), .out_dim(od), .out_data(odata),
        .out_empty(out_empty), .busy(busy), .done(done),
        .acc_overflow(ovf)
    );

    int n_chk = 0;
    int n_fail = 0;
    longint unsigned m_sum [3][4];
    longint unsigned m_cnt [3];
    bit  m_ovf = 0;
    int  e_data [12];
    bit  e_empty [12];
    int  n_acc = 0;
    int  n_done = 0;
    bit  chk_on = 0;

    task automatic check(string nm, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_clear();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            for (int d = 0; d < 4; d++) m_sum[k][d] = 0;
        end
        m_ovf = 0;
    endfunction

    function automatic void m_point(int a, int b, int c, int e, int k);
        int x [4];
        x = '{a, b, c, e};
        if (k > 2) return;
        for (int d = 0; d < 4; d++) begin
            m_sum[k][d] = m_sum[k][d] + longint'(x[d]);
            if (m_sum[k][d] >= 64'h1_0000_0000) begin
                m_ovf = 1;
                m_sum[k][d] = m_sum[k][d] - 64'h1_0000_0000;
            end
        end
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] >= 65536) begin
            m_ovf = 1;
            m_cnt[k] = 0;
        end
    endfunction

    function automatic void m_finish();
        for (int i = 0; i < 12; i++) begin
            if (m_cnt[i/4] == 0) begin
                e_data[i]  = 0;
                e_empty[i] = 1;
            end else begin
                e_data[i]  = int'((m_sum[i/4][i%4] / m_cnt[i/4]) % 65536);
                e_empty[i] = 0;
            end
        end
        n_acc  = 0;
        n_done = 0;
    endfunction

    // single checker for streamed results and the sticky overflow flag
    always @(negedge clk) begin
        if (chk_on) begin
            check("acc_overflow", ovf, m_ovf);
            if (out_valid) begin
                if (n_acc >= 12) begin
                    check("extra_result", n_acc, 11);
                end else begin
                    check("out_centroid", oc, n_acc / 4);
                    check("out_dim", od, n_acc % 4);
                    check("out_data", odata, e_data[n_acc]);
                    check("out_empty", out_empty, e_empty[n_acc]);
                end
                if (out_ready) n_acc++;
            end
            if (done) n_done++;
        end
    end

    task automatic do_reset();
        chk_on = 0;
        start = 0;
        in_valid = 0;
        in_last = 0;
        rst = 1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_out_data", odata, 0);
        check("rst_out_centroid", oc, 0);
        check("rst_out_dim", od, 0);
        check("rst_out_empty", out_empty, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        m_clear();
        n_acc = 0;
        n_done = 0;
        chk_on = 1;
    endtask

    task automatic pulse_start(bit eff);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        if (eff) m_clear();
    endtask

    task automatic send(int a, int b, int c, int e, int k, bit last);
        d0 = 16'(a); d1 = 16'(b); d2 = 16'(c); d3 = 16'(e);
        sel = 2'(k);
        in_valid = 1;
        in_last = last;
        @(posedge clk);
        #1 in_valid = 0;
        in_last = 0;
        m_point(a, b, c, e, k);
        if (last) m_finish();
    endtask

    task automatic wait_done(string nm);
        bit seen = 0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check({nm, "_done_seen"}, seen, 1);
        @(negedge clk);
        check({nm, "_done_count"}, n_done, 1);
        check({nm, "_results"}, n_acc, 12);
        check({nm, "_idle"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lit [12];
        #1;
        do_reset();

        // reset in the middle of accumulation
        pulse_start(1);
        send(100, 200, 300, 400, 0, 0);
        send(50, 60, 70, 80, 1, 0);
        send(9, 9, 9, 9, 2, 0);
        check("mid_busy", busy, 1);
        do_reset();

        // basic means, first result stalled for 20 cycles
        pulse_start(1);
        out_ready = 0;
        send(10, 20, 30, 40, 0, 0);
        send(20, 40, 60, 80, 0, 0);
        send(5, 5, 5, 5, 1, 0);
        send(7, 8, 9, 10, 2, 1);
        lit = '{15, 30, 45, 60, 5, 5, 5, 5, 7, 8, 9, 10};
        for (int i = 0; i < 12; i++) begin
            check("pin_basic", e_data[i], lit[i]);
        end
        begin
            int w = 0;
            while (!out_valid && w < 200) begin
                @(negedge clk);
                w++;
            end
        end
        check("stall_first_valid", out_valid, 1);
        repeat (20) begin
            @(negedge clk);
            check("stall_hold", out_valid, 1);
        end
        @(posedge clk);
        #1 out_ready = 1;
        wait_done("basic");

        // empty clusters
        pulse_start(1);
        send(1, 2, 3, 4, 0, 0);
        send(1, 2, 3, 4, 0, 0);
        send(1, 2, 3, 4, 0, 1);
        check("pin_empty_d3", e_data[3], 4);
        check("pin_empty_k1", e_empty[4], 1);
        check("pin_empty_k2", e_empty[8], 1);
        wait_done("empty");

        // truncating mean and dropped selections
        pulse_start(1);
        send(3, 0, 0, 0, 2, 0);
        send(50, 50, 50, 50, 3, 0);
        send(4, 1, 0, 65535, 2, 0);
        send(60, 61, 62, 63, 3, 0);
        send(1000, 1000, 1000, 1000, 3, 1);
        lit = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 32767};
        for (int i = 8; i < 12; i++) begin
            check("pin_trunc", e_data[i], lit[i]);
        end
        wait_done("trunc");

        // counter wrap; start during DIV is ignored
        pulse_start(1);
        for (int i = 0; i < 65537; i++) begin
            send(65535, 0, 0, 0, 0, i == 65536);
            if (i == 65534) check("ovf_before_wrap", ovf, 0);
            if (i == 65535) check("ovf_at_wrap", ovf, 1);
        end
        check("pin_wrap_data", e_data[0], 65535);
        check("pin_wrap_cnt", m_cnt[0], 1);
        pulse_start(0);
        wait_done("wrap");
        check("ovf_sticky", ovf, 1);

        // restart inside ACCUM; start beats a coincident point
        pulse_start(1);
        check("ovf_cleared", ovf, 0);
        send(100, 100, 100, 100, 0, 0);
        send(1, 1, 1, 1, 1, 0);
        pulse_start(1);
        d0 = 999; d1 = 999; d2 = 999; d3 = 999;
        sel = 0;
        in_valid = 1;
        pulse_start(1);
        in_valid = 0;
        send(8, 6, 4, 2, 0, 0);
        send(3, 3, 3, 3, 1, 1);
        check("pin_restart_k0", e_data[0], 8);
        check("pin_restart_k1", e_data[4], 3);
        check("pin_restart_k2", e_empty[8], 1);
        wait_done("restart");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/kmeans_centroid_update_k3_d4.md
Name: kmeans_centroid_update_k3_d4

Overview:
Consumer end of the 3-centroid, 4-dimension k-means assignment pipeline. It takes each classified point (output_data0..3 plus selected_centroid) and accumulates a per-centroid, per-dimension sum and a per-centroid point count. At end of epoch it computes each new centroid coordinate as sum/count with a sequential divider, then streams the 12 results out over a valid/ready handshake for loading back into the assignment pipeline.

Parameters:
input_data_width, 16, width of point coordinates and result coordinates (unsigned)
acc_width, 32, width of each per-dimension sum accumulator
cnt_width, 16, width of each per-centroid point counter

Ports:
clk  in  1  clock, all state rising-edge
rst  in  1  asynchronous active-high reset
start  in  1  pulse; clears accumulators and begins an epoch
in_valid  in  1  current point/selection valid
in_last  in  1  qualifies in_valid; marks final point of epoch
input_data0..input_data3  in  input_data_width each  point coordinates (from pipeline output_data0..3)
selected_centroid  in  2  assigned centroid index 0..2
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_centroid  out  2  centroid index of result
out_dim  out  2  dimension index of result
out_data  out  input_data_width  new coordinate = floor(sum/count)
out_empty  out  1  centroid had count 0; out_data forced 0
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after last result accepted
acc_overflow  out  1  sticky; any sum or count wrapped this epoch

Behaviour:
- Reset (async, any state): state IDLE; all sums, counts, divider regs 0; out_valid, out_centroid, out_dim, out_data, out_empty, busy, done, acc_overflow all 0.
- FSM states: IDLE, ACCUM, DIV, OUT.
- IDLE: start -> clear 12 sums, 3 counts, acc_overflow; go ACCUM next cycle. in_valid ignored.
- ACCUM: in_valid with selected_centroid=k (k<=2) -> sum[k][d] += input_data_d (zero-extended) for d=0..3, count[k] += 1, in the same cycle. selected_centroid=3 -> point dropped, no state change. Carry out of any sum or count sets acc_overflow; value wraps modulo width.
- ACCUM: in_valid&in_last -> that point is accumulated, then go DIV with pair index (k=0,d=0). start in ACCUM -> clear and stay ACCUM (restart epoch); start has priority over a coincident in_valid.
- DIV: restoring divider, 1 quotient bit/cycle, acc_width cycles, dividend sum[k][d], divisor zero-extended count[k]. count[k]=0 -> skip division (1 cycle), result 0, out_empty=1. Quotient truncated to input_data_width (fits when no overflow). Then go OUT.
- OUT: out_valid=1, outputs stable until out_valid&out_ready. On accept: advance d, then k (order k0d0,k0d1..k2d3); return to DIV. Accept of k=2,d=3 -> done pulse next cycle, go IDLE, out_valid low.
- Latency: acc_width+1 cycles from DIV entry to out_valid (2 for empty cluster); minimum 12*(acc_width+2) cycles last-point to done with out_ready held high.
- start, in_valid ignored in DIV/OUT. Accumulators retain values after done until next start.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset mid-ACCUM after 3 points -> all outputs 0, busy=0; new start+points give results unaffected by pre-reset data.
- start; points (10,20,30,40)->k0, (20,40,60,80)->k0, (5,5,5,5)->k1, (7,8,9,10)->k2 with last -> stream k0:(15,30,45,60), k1:(5,5,5,5), k2:(7,8,9,10), out_empty=0, done once.
- start; 3 points (1,2,3,4)->k0, k1 never selected, in_last -> k0 results (1,2,3,4); k1 four results out_data=0 out_empty=1; 12 results total.
- Non-integer mean: (3,0,0,0)->k2, (4,1,0,65535)->k2 -> k2:(3,0,0,32767); selected_centroid=3 points interleaved change nothing.
- out_ready held low 20 cycles on first result -> out_valid stays 1, out_data/out_centroid/out_dim stable; no result skipped or repeated.
- 65537 points of 65535 to k0 with cnt_width=16 -> acc_overflow=1 at wrap, stays 1 until next start; start in DIV ignored, start in ACCUM restarts with all sums 0.
